// File: rtl/uart_mmio_bridge_pkg.sv
// ---------------------------------------------------------------------------
// uart_mmio_bridge_pkg
// Shared definitions for the UART memory-mapped bridge: register addresses,
// the UART register-bus width and the transmit state encoding.
// ---------------------------------------------------------------------------
package uart_mmio_bridge_pkg;

    // Width of the byte path between the CPU registers and the UART.
    localparam int UART_REG_W = 8;

    // CPU-visible register map.
    localparam logic [15:0] DATA_ADDR   = 16'hBF00;
    localparam logic [15:0] STATUS_ADDR = 16'hBF01;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// ---------------------------------------------------------------------------
// uart_fifo
// Small synchronous FIFO used for both the TX and RX byte queues.
//   clk, rst       : clock, asynchronous active-high reset
//   push, din      : write strobe and data; ignored when full unless a pop
//                    happens in the same cycle
//   pop, dout      : read strobe (ignored when empty) and head-of-queue data
//   full, empty    : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        pop_ok   = pop && !empty;
        // A full FIFO can still accept a byte when the head leaves this cycle.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which entries are valid, and a reset-free array maps to
    // plain RAM/register cells.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_bridge.sv
// ---------------------------------------------------------------------------
// uart_mmio_bridge
// Bridges a simple CPU memory bus to a byte-oriented UART transmitter and
// receiver through a TX FIFO and an RX FIFO.
//   clk, rst           : clock, asynchronous active-high reset
//   mem_ce/we/addr     : CPU access strobe, direction and byte address
//   mem_wdata          : write data (bits 7:0 used)
//   mem_rdata          : combinational read data
//   tx_start, tx_data  : start pulse (2 clk wide) and byte to the transmitter
//   tx_busy            : transmitter busy
//   rx_ready, rx_data  : receiver data-ready level and received byte
// Registers: DATA (write = queue TX byte, read = pop RX byte) and
// STATUS = {13'b0, overrun, rx_nonempty, tx_notfull}; reading STATUS clears
// overrun.
// ---------------------------------------------------------------------------
module uart_mmio_bridge
    import uart_mmio_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ce,
    input  logic                  mem_we,
    input  logic [15:0]           mem_addr,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  tx_start,
    output logic [UART_REG_W-1:0] tx_data,
    input  logic                  tx_busy,
    input  logic                  rx_ready,
    input  logic [UART_REG_W-1:0] rx_data
);

    tx_state_e             state_q, state_d;
    logic                  start_cnt_q, start_cnt_d;
    logic [UART_REG_W-1:0] tx_data_q, tx_data_d;
    logic                  overrun_q, overrun_d;
    logic                  rx_ready_q, rx_ready_d;

    logic                  data_rd, data_wr, status_rd;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic [UART_REG_W-1:0] tx_head, rx_head;
    logic                  unused_wdata;

    assign unused_wdata = ^mem_wdata[15:UART_REG_W];

    // Bus decode, RX edge detect, overrun tracking and read mux.
    always_comb begin
        data_rd    = mem_ce && !mem_we && (mem_addr == DATA_ADDR);
        data_wr    = mem_ce &&  mem_we && (mem_addr == DATA_ADDR);
        status_rd  = mem_ce && !mem_we && (mem_addr == STATUS_ADDR);
        tx_push    = data_wr;
        rx_pop     = data_rd && !rx_empty;
        // One push per rising edge of rx_ready, however long it stays high.
        rx_push    = rx_ready && !rx_ready_q;
        rx_ready_d = rx_ready;
        // Set has priority over the read-to-clear.
        overrun_d  = (rx_push && rx_full && !rx_pop) ||
                     (overrun_q && !status_rd);
        mem_rdata  = 16'h0000;
        if (rx_pop) begin
            mem_rdata = {8'h00, rx_head};
        end else if (status_rd) begin
            mem_rdata = {13'b0, overrun_q, !rx_empty, !tx_full};
        end
    end

    // Transmit sequencer: load a byte, pulse tx_start for two clocks, then
    // follow tx_busy high and back low before taking the next byte.
    always_comb begin
        state_d     = state_q;
        start_cnt_d = 1'b0;
        tx_data_d   = tx_data_q;
        tx_pop      = 1'b0;
        tx_start    = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_pop    = 1'b1;
                    tx_data_d = tx_head;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                tx_start    = 1'b1;
                start_cnt_d = 1'b1;
                if (start_cnt_q) begin
                    start_cnt_d = 1'b0;
                    state_d     = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign tx_data = tx_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            start_cnt_q <= 1'b0;
            tx_data_q   <= '0;
            overrun_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            tx_data_q   <= tx_data_d;
            overrun_q   <= overrun_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_REG_W)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_wdata[UART_REG_W-1:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_REG_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

endmodule
